// File: rtl/keypad_scanner.sv
// Scans and debounces a 4x3 matrix keypad into a held key code plus a one-cycle strobe per press.
// Optional `KEY_REPEAT_EN adds an auto-repeat strobe every REPEAT_SCANS samples while a key is held.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV       = 1000,
   parameter int unsigned DEBOUNCE_SCANS = 4,
   parameter logic [3:0]  NO_KEY         = 4'd10,
   parameter int unsigned REPEAT_SCANS   = 50
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [2:0] col,
   output logic [3:0] key,
   output logic       key_strobe
);

   localparam int unsigned DIV_W = 16;
   localparam int unsigned CNT_W = 4;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_SCANS);

   localparam logic [1:0] SCAN     = 2'd0;
   localparam logic [1:0] PRESS_DB = 2'd1;
   localparam logic [1:0] HELD     = 2'd2;
   localparam logic [1:0] REL_DB   = 2'd3;

   // Elaboration-time parameter range checks
   generate
      if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_bad_scan_div
         $error("keypad_scanner: SCAN_DIV out of range 2..65535");
      end
      if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
         $error("keypad_scanner: DEBOUNCE_SCANS out of range 1..15");
      end
      if (REPEAT_SCANS < 1 || REPEAT_SCANS > 255) begin : g_bad_repeat
         $error("keypad_scanner: REPEAT_SCANS out of range 1..255");
      end
   endgenerate

   logic [3:0]       row_s1, row_s2;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   logic [1:0]       state, state_d;
   logic [2:0]       col_d;
   logic [3:0]       key_d;
   logic             strobe_d;
   logic [3:0]       cap_code, cap_code_d;
   logic [CNT_W-1:0] db_cnt, db_cnt_d, db_inc;

   logic [1:0]       col_idx;
   logic             samp_valid;
   logic             samp_zero;
   logic [3:0]       samp_code;
   logic             rep_fire;

   // Two-flop synchronizer for the asynchronous row inputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         row_s1 <= '0;
         row_s2 <= '0;
      end else begin
         row_s1 <= row;
         row_s2 <= row_s1;
      end
   end

   // Column dwell divider; the sample tick is its last count
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   assign tick   = (div_cnt == DIV_LAST);
   assign db_inc = db_cnt + CNT_W'(1);

   // Row/column decode: only single-row samples produce a code
   always_comb begin
      samp_valid = 1'b0;
      samp_code  = NO_KEY;
      samp_zero  = (row_s2 == 4'b0000);
      case (col)
         3'b010:  col_idx = 2'd1;
         3'b100:  col_idx = 2'd2;
         default: col_idx = 2'd0;
      endcase
      case (row_s2)
         4'b0001: begin
            samp_valid = 1'b1;
            samp_code  = 4'd1 + {2'b00, col_idx};
         end
         4'b0010: begin
            samp_valid = 1'b1;
            samp_code  = 4'd4 + {2'b00, col_idx};
         end
         4'b0100: begin
            samp_valid = 1'b1;
            samp_code  = 4'd7 + {2'b00, col_idx};
         end
         4'b1000: begin
            samp_valid = 1'b1;
            case (col_idx)
               2'd0:    samp_code = 4'd11;
               2'd1:    samp_code = 4'd0;
               default: samp_code = 4'd12;
            endcase
         end
         default: begin
            samp_valid = 1'b0;
         end
      endcase
   end

`ifdef KEY_REPEAT_EN
   localparam int unsigned      REP_W    = 8;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS);

   logic [REP_W-1:0] rep_cnt, rep_cnt_d;

   // Repeat counter runs only while a key stays held; any other tick clears it
   always_comb begin
      rep_cnt_d = rep_cnt;
      rep_fire  = 1'b0;
      if (tick) begin
         if (state == HELD && !samp_zero) begin
            if (rep_cnt + REP_W'(1) == REP_LAST) begin
               rep_fire  = 1'b1;
               rep_cnt_d = '0;
            end else begin
               rep_cnt_d = rep_cnt + REP_W'(1);
            end
         end else begin
            rep_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rep_cnt <= '0;
      end else begin
         rep_cnt <= rep_cnt_d;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   // Scan/debounce FSM state and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= SCAN;
         col        <= 3'b001;
         key        <= NO_KEY;
         key_strobe <= 1'b0;
         cap_code   <= '0;
         db_cnt     <= '0;
      end else begin
         state      <= state_d;
         col        <= col_d;
         key        <= key_d;
         key_strobe <= strobe_d;
         cap_code   <= cap_code_d;
         db_cnt     <= db_cnt_d;
      end
   end

   always_comb begin
      state_d    = state;
      col_d      = col;
      key_d      = key;
      strobe_d   = 1'b0;
      cap_code_d = cap_code;
      db_cnt_d   = db_cnt;
      if (tick) begin
         case (state)
            SCAN: begin
               if (samp_valid) begin
                  cap_code_d = samp_code;
                  db_cnt_d   = CNT_W'(1);
                  if (DB_LAST == CNT_W'(1)) begin
                     state_d  = HELD;
                     key_d    = samp_code;
                     strobe_d = 1'b1;
                  end else begin
                     state_d = PRESS_DB;
                  end
               end else begin
                  col_d = {col[1:0], col[2]};
               end
            end
            PRESS_DB: begin
               if (samp_valid && samp_code == cap_code) begin
                  db_cnt_d = db_inc;
                  if (db_inc == DB_LAST) begin
                     state_d  = HELD;
                     key_d    = cap_code;
                     strobe_d = 1'b1;
                  end
               end else begin
                  state_d = SCAN;
               end
            end
            HELD: begin
               // Only an empty row counts as a release candidate here
               if (samp_zero) begin
                  db_cnt_d = CNT_W'(1);
                  if (DB_LAST == CNT_W'(1)) begin
                     state_d = SCAN;
                     key_d   = NO_KEY;
                  end else begin
                     state_d = REL_DB;
                  end
               end
            end
            default: begin
               if (samp_zero) begin
                  db_cnt_d = db_inc;
                  if (db_inc == DB_LAST) begin
                     state_d = SCAN;
                     key_d   = NO_KEY;
                  end
               end else begin
                  state_d = HELD;
               end
            end
         endcase
      end
      if (rep_fire) begin
         strobe_d = 1'b1;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized self-checking bench for keypad_scanner against a per-sample keypad model.
// Covers the auto-repeat strobe too when KEY_REPEAT_EN is defined.
module tb_keypad_scanner;

   localparam int DIV = 4;
   localparam int DB  = 3;
   localparam int RS  = 5;
   localparam logic [3:0] NOKEY = 4'd10;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] row   = 4'b0000;
   logic [2:0] col;
   logic [3:0] key;
   logic       key_strobe;

   int n_checks = 0;
   int n_errors = 0;

   // Keypad layout: index = row*3 + column
   int key_tab[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 0, 12};

   // Reference model of the sample-by-sample behaviour
   int         m_mode;   // 0 scanning, 1 confirming press, 2 held, 3 confirming release
   int         m_c;      // driven column index
   int         m_cand;
   int         m_streak;
   int         m_rel;
   int         m_rep;
   logic [3:0] m_key;
   logic       m_strobe;

   logic [3:0] obs_key, prev_key;
   logic [2:0] obs_col, prev_col;
   logic       obs_strobe, obs_glitch;

   keypad_scanner #(
      .SCAN_DIV      (DIV),
      .DEBOUNCE_SCANS(DB),
      .NO_KEY        (NOKEY),
      .REPEAT_SCANS  (RS)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .row       (row),
      .col       (col),
      .key       (key),
      .key_strobe(key_strobe)
   );

   always #5 clock = ~clock;

   function automatic logic [2:0] onehot(input int c);
      logic [2:0] v;
      v = 3'b001 << c;
      return v;
   endfunction

   // Physical keypad: a pressed key shows on its row only while its column is driven
   function automatic logic [3:0] key_rows(input int k, input int c);
      for (int i = 0; i < 12; i++) begin
         if (key_tab[i] == k && (i % 3) == c) return 4'(1 << (i / 3));
      end
      return 4'b0000;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_c = 0; m_cand = 0; m_streak = 0; m_rel = 0; m_rep = 0;
      m_key = NOKEY; m_strobe = 1'b0;
      prev_key = NOKEY; prev_col = 3'b001;
   endtask

   task automatic model_tick(input logic [3:0] r);
      bit valid;
      int ridx, code;
      valid = ($countones(r) == 1);
      ridx = 0;
      for (int i = 0; i < 4; i++) if (r[i]) ridx = i;
      code = valid ? key_tab[ridx * 3 + m_c] : -1;
      m_strobe = 1'b0;
      case (m_mode)
         0: begin
            if (valid) begin
               m_cand = code; m_streak = 1; m_mode = 1;
            end else begin
               m_c = (m_c + 1) % 3;
            end
         end
         1: begin
            if (valid && code == m_cand) m_streak++;
            else m_mode = 0;
         end
         2: begin
            if (r == 4'b0000) begin
               m_rel = 1; m_rep = 0; m_mode = 3;
            end else begin
               m_rep++;
`ifdef KEY_REPEAT_EN
               if (m_rep == RS) begin m_strobe = 1'b1; m_rep = 0; end
`endif
            end
         end
         default: begin
            m_rep = 0;
            if (r == 4'b0000) m_rel++;
            else m_mode = 2;
         end
      endcase
      if (m_mode == 1 && m_streak >= DB) begin
         m_mode = 2; m_key = 4'(m_cand); m_strobe = 1'b1; m_rep = 0;
      end
      if (m_mode == 3 && m_rel >= DB) begin
         m_mode = 0; m_key = NOKEY;
      end
   endtask

   // One sample period: s >= 100 drives raw row (s-100), else presses key s (-1 = nothing)
   task automatic drive(input int s);
      logic [3:0] r;
      r = (s >= 100) ? 4'(s - 100) : key_rows(s, m_c);
      row = r;
      obs_glitch = 1'b0;
      for (int k = 1; k <= DIV; k++) begin
         @(posedge clock);
         #1;
         if (k < DIV && (key_strobe !== 1'b0 || key !== prev_key || col !== prev_col))
            obs_glitch = 1'b1;
      end
      model_tick(r);
      obs_key = key; obs_col = col; obs_strobe = key_strobe;
      prev_key = key; prev_col = col;
   endtask

   task automatic test_reset();
      int seq[] = '{-1, -1, -1, -1, -1, -1, -1};
      repeat (3) @(posedge clock);
      #1;
      n_checks++;
      if (key !== NOKEY || col !== 3'b001 || key_strobe !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_values: got key=%0d col=%b strobe=%b, want key=10 col=001 strobe=0",
                  key, col, key_strobe);
      end
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      foreach (seq[i]) begin
         drive(seq[i]);
         n_checks++;
         if ({obs_key, obs_col, obs_strobe, obs_glitch} !== {m_key, onehot(m_c), m_strobe, 1'b0}) begin
            n_errors++;
            $display("FAIL idle_scan step %0d: got key=%0d col=%b strobe=%b glitch=%b, want key=%0d col=%b strobe=%b glitch=0",
                     i, obs_key, obs_col, obs_strobe, obs_glitch, m_key, onehot(m_c), m_strobe);
         end
      end
   endtask

   task automatic test_press();
      int seq[] = '{5, 5, 5, 5, 5, 5, 5};
      foreach (seq[i]) begin
         drive(seq[i]);
         n_checks++;
         if ({obs_key, obs_col, obs_strobe, obs_glitch} !== {m_key, onehot(m_c), m_strobe, 1'b0}) begin
            n_errors++;
            $display("FAIL press_5 step %0d: got key=%0d col=%b strobe=%b glitch=%b, want key=%0d col=%b strobe=%b glitch=0",
                     i, obs_key, obs_col, obs_strobe, obs_glitch, m_key, onehot(m_c), m_strobe);
         end
      end
   endtask

   task automatic test_bounce();
      int seq[] = '{-1, -1, -1, 5, -1, 5, -1, 5, -1, 5, -1, 5, 5, 5, 5, 5, 5, 5};
      foreach (seq[i]) begin
         drive(seq[i]);
         n_checks++;
         if ({obs_key, obs_col, obs_strobe, obs_glitch} !== {m_key, onehot(m_c), m_strobe, 1'b0}) begin
            n_errors++;
            $display("FAIL bounce step %0d: got key=%0d col=%b strobe=%b glitch=%b, want key=%0d col=%b strobe=%b glitch=0",
                     i, obs_key, obs_col, obs_strobe, obs_glitch, m_key, onehot(m_c), m_strobe);
         end
      end
   endtask

   task automatic test_release_glitch();
      int seq[] = '{-1, 5, 5, -1, -1, -1, -1, -1, -1};
      foreach (seq[i]) begin
         drive(seq[i]);
         n_checks++;
         if ({obs_key, obs_col, obs_strobe, obs_glitch} !== {m_key, onehot(m_c), m_strobe, 1'b0}) begin
            n_errors++;
            $display("FAIL release step %0d: got key=%0d col=%b strobe=%b glitch=%b, want key=%0d col=%b strobe=%b glitch=0",
                     i, obs_key, obs_col, obs_strobe, obs_glitch, m_key, onehot(m_c), m_strobe);
         end
      end
   endtask

   task automatic test_multi_row();
      int seq[] = '{103, 103, 103, 103, 0, 0, 0, 0, 0, 0, -1, -1, -1,
                    11, 11, 11, 11, 11, 11, -1, -1, -1, 12, 12, 12, 12, 12, 12, -1, -1, -1};
      foreach (seq[i]) begin
         drive(seq[i]);
         n_checks++;
         if ({obs_key, obs_col, obs_strobe, obs_glitch} !== {m_key, onehot(m_c), m_strobe, 1'b0}) begin
            n_errors++;
            $display("FAIL multi_row_edges step %0d: got key=%0d col=%b strobe=%b glitch=%b, want key=%0d col=%b strobe=%b glitch=0",
                     i, obs_key, obs_col, obs_strobe, obs_glitch, m_key, onehot(m_c), m_strobe);
         end
      end
   endtask

   task automatic test_reset_held();
      int pre[]  = '{9, 9, 9, 9, 9, 9};
      int post[] = '{9, 9, 9, 9, 9, 9, -1, -1, -1};
      foreach (pre[i]) begin
         drive(pre[i]);
         n_checks++;
         if ({obs_key, obs_col, obs_strobe, obs_glitch} !== {m_key, onehot(m_c), m_strobe, 1'b0}) begin
            n_errors++;
            $display("FAIL hold_9 step %0d: got key=%0d col=%b strobe=%b glitch=%b, want key=%0d col=%b strobe=%b glitch=0",
                     i, obs_key, obs_col, obs_strobe, obs_glitch, m_key, onehot(m_c), m_strobe);
         end
      end
      reset = 1'b1;
      #2;
      n_checks++;
      if (key !== NOKEY || col !== 3'b001 || key_strobe !== 1'b0) begin
         n_errors++;
         $display("FAIL async_reset_in_held: got key=%0d col=%b strobe=%b, want key=10 col=001 strobe=0",
                  key, col, key_strobe);
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      foreach (post[i]) begin
         drive(post[i]);
         n_checks++;
         if ({obs_key, obs_col, obs_strobe, obs_glitch} !== {m_key, onehot(m_c), m_strobe, 1'b0}) begin
            n_errors++;
            $display("FAIL redetect_9 step %0d: got key=%0d col=%b strobe=%b glitch=%b, want key=%0d col=%b strobe=%b glitch=0",
                     i, obs_key, obs_col, obs_strobe, obs_glitch, m_key, onehot(m_c), m_strobe);
         end
      end
   endtask

   task automatic test_repeat();
      int seq[$];
      repeat (22) seq.push_back(2);
      repeat (4) seq.push_back(-1);
      foreach (seq[i]) begin
         drive(seq[i]);
         n_checks++;
         if ({obs_key, obs_col, obs_strobe, obs_glitch} !== {m_key, onehot(m_c), m_strobe, 1'b0}) begin
            n_errors++;
            $display("FAIL hold_2_repeat step %0d: got key=%0d col=%b strobe=%b glitch=%b, want key=%0d col=%b strobe=%b glitch=0",
                     i, obs_key, obs_col, obs_strobe, obs_glitch, m_key, onehot(m_c), m_strobe);
         end
      end
   endtask

   task automatic test_random();
      int seq[$];
      int k;
      for (int it = 0; it < 30; it++) begin
         k = key_tab[$urandom_range(0, 11)];
         if ($urandom_range(0, 3) == 0) seq.push_back(100 + int'($urandom_range(0, 15)));
         repeat ($urandom_range(1, 9)) seq.push_back(($urandom_range(0, 5) == 0) ? -1 : k);
         repeat ($urandom_range(1, 6)) seq.push_back(-1);
      end
      foreach (seq[i]) begin
         drive(seq[i]);
         n_checks++;
         if ({obs_key, obs_col, obs_strobe, obs_glitch} !== {m_key, onehot(m_c), m_strobe, 1'b0}) begin
            n_errors++;
            $display("FAIL random step %0d (stim %0d): got key=%0d col=%b strobe=%b glitch=%b, want key=%0d col=%b strobe=%b glitch=0",
                     i, seq[i], obs_key, obs_col, obs_strobe, obs_glitch, m_key, onehot(m_c), m_strobe);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_press();
      test_bounce();
      test_release_glitch();
      test_multi_row();
      test_reset_held();
      test_repeat();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans and debounces a 4x3 matrix keypad (digits 0-9, *, #).
- Sits directly upstream of the alarm clock top and drives its `key` input.
- Output is a held 4-bit key code, plus a one-cycle strobe per accepted press.
- Runs on the system clock; the column-dwell divider is internal.

Parameters:
- SCAN_DIV, 1000: clocks per column dwell and per row sample; legal range 2 to 65535.
- DEBOUNCE_SCANS, 4: consecutive identical samples needed to accept a press or a release; legal range 1 to 15.
- NO_KEY, 4'd10: code driven on `key` when no key is accepted.
- REPEAT_SCANS, 50: samples between auto-repeat strobes; used only when KEY_REPEAT_EN is defined; legal range 1 to 255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- row  in  4  keypad rows, active-high, asynchronous to clock.
- col  out  3  column drive, one-hot, active-high.
- key  out  4  accepted key code, else NO_KEY.
- key_strobe  out  1  one-cycle pulse when a new key code is accepted.

Behaviour:
- Reset values: col=3'b001, key=NO_KEY, key_strobe=0, state=SCAN, all counters 0.
- Row input path:
  - `row` passes through a 2-flop synchronizer before any use.
  - The divider counts 0..SCAN_DIV-1. The synchronized row is sampled when the divider is at SCAN_DIV-1 (the sample tick).
- Decode:
  - A sample is valid only if exactly one row bit is set.
  - A zero-row or multi-row sample counts as "none".
  - Row/col map: r0 gives 1,2,3; r1 gives 4,5,6; r2 gives 7,8,9; r3 gives *,0,#.
  - Codes are the digits 0-9 as values, *=11, #=12.
- State SCAN:
  - On each sample tick with a "none" sample, col rotates 001->010->100->001.
  - On a valid sample: col freezes, the code is captured, debounce count=1, go to PRESS_DB.
- State PRESS_DB (col frozen):
  - Each tick whose sample matches the captured code increments the count.
  - A mismatch or "none" returns to SCAN. col resumes rotation on the next tick.
  - When the count reaches DEBOUNCE_SCANS: go to HELD. On the next clock, key=code and key_strobe=1 for exactly one cycle.
  - With DEBOUNCE_SCANS=1 the key is accepted on the first tick.
- State HELD:
  - key holds the code.
  - A "none" sample sets release count=1 and goes to REL_DB.
  - A different valid or multi-row sample is treated as still held; no new strobe.
- State REL_DB:
  - Each "none" tick increments the release count. Any non-"none" sample returns to HELD with no strobe.
  - When the count reaches DEBOUNCE_SCANS: key=NO_KEY on the next clock, col resumes rotation, go to SCAN.
- Accept latency: 1 clock after the accepting sample tick. The row-to-sample delay adds 2 clocks of synchronizer delay.
- Reset asserted mid-operation: immediately returns all outputs to reset values. A key still held after reset is re-detected through the normal SCAN/PRESS_DB path and gets a fresh strobe.
- key changes only on the accept and release transitions. key_strobe is never asserted in two consecutive cycles.

Optional Feature:
- Macro KEY_REPEAT_EN.
- When defined:
  - In HELD, a repeat counter increments on every sample tick.
  - On reaching REPEAT_SCANS it asserts key_strobe for one cycle and clears. key is unchanged.
  - The counter clears on entry to HELD and in REL_DB.
- When undefined: the repeat counter is not built, and there is exactly one strobe per accepted press.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=5):
1. Reset release, no rows high -> col cycles 001,010,100 every 4 clocks; key=10; key_strobe=0 throughout.
2. Hold row=4'b0010 while col=010 (digit 5) -> col freezes at 010; key=5 and a single key_strobe appear 1 clock after the 3rd matching sample tick; key stays 5 while held.
3. Bounce: row toggles 0010/0000 on alternate sample ticks, then stays steady -> no strobe during bouncing; exactly one strobe and key=5 after 3 stable ticks.
4. Release after HELD: one "none" tick then a press tick -> stays HELD, key=5, no strobe; three "none" ticks -> key=10 and col rotation resumes.
5. row=4'b0011 (two rows) in SCAN -> treated as "none", col keeps rotating, key=10; row=4'b1000 with col=010 -> key=0; with col=001 -> key=11 (*); with col=100 -> key=12 (#).
6. Assert reset while in HELD with key=9 -> key=10 and col=001 immediately. With KEY_REPEAT_EN defined and digit 2 held -> one strobe on accept, then one strobe every 5 sample ticks, key=2 constant.
